// File: rtl/alpharetz_spi_pkg.sv
// Shared types and default parameters for the Alpharetz SPI peripheral.
// Defaults mirror the values kept in alpharetz_spi_params.svh.
package alpharetz_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

  localparam int DEF_SPI_DATA_WIDTH = 8;
  localparam int DEF_CPOL           = 0;
  localparam int DEF_CPHA           = 0;
  localparam int DEF_SYNC_STAGES    = 2;

  // Leading edge leaves the idle level, so with CPOL=1 it is the falling edge.
  function automatic logic lead_edge(input int cpol, input logic rise, input logic fall);
    return (cpol == 0) ? rise : fall;
  endfunction

endpackage

// File: rtl/alpharetz_spi_sync_edge.sv
// Multi-stage synchroniser with single-cycle rise/fall pulses taken from the
// last two synchronised samples; RST_VAL sets the idle level after reset.
module alpharetz_spi_sync_edge
  import alpharetz_spi_pkg::*;
#(
  parameter int   STAGES  = DEF_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic async_rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) begin
      sync_r <= {STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/alpharetz_spi_peripheral.sv
// SPI target endpoint: oversampled p_clk/p_sel_n/copi, LSB-first shifting, one
// buffered TX word. Optional ALPHARETZ_SPI_PERI_UNDERRUN_EN adds tx_underrun.
module alpharetz_spi_peripheral
  import alpharetz_spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = DEF_SPI_DATA_WIDTH,
  parameter int CPOL           = DEF_CPOL,
  parameter int CPHA           = DEF_CPHA,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                      sys_clk,
  input  logic                      async_rst,
  input  logic                      p_clk,
  input  logic                      p_sel_n,
  input  logic                      copi,
  output logic                      cipo,
  output logic                      cipo_oe,
  input  logic [SPI_DATA_WIDTH-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [SPI_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      busy
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
  ,
  output logic                      tx_underrun
`endif
);

  localparam int               CNT_W    = $clog2(SPI_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SPI_DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPI_DATA_WIDTH - 1);
  localparam logic             CPOL_BIT = (CPOL != 0);

  spi_state_e                state_r;
  logic [SPI_DATA_WIDTH-1:0] shreg_r;
  logic [SPI_DATA_WIDTH-1:0] txbuf_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      close_r;
  logic [SYNC_STAGES-1:0]    copi_sync_r;

  logic pclk_rise_s, pclk_fall_s, sel_rise_s, sel_fall_s;
  logic lead_s, trail_s, sample_s, shift_s, copi_s, frame_start_s;
  logic [SPI_DATA_WIDTH-1:0] frame_word_s;

  alpharetz_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL_BIT)) u_pclk_sync (
    .sys_clk   (sys_clk),
    .async_rst (async_rst),
    .d         (p_clk),
    .rise      (pclk_rise_s),
    .fall      (pclk_fall_s)
  );

  alpharetz_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sel_sync (
    .sys_clk   (sys_clk),
    .async_rst (async_rst),
    .d         (p_sel_n),
    .rise      (sel_rise_s),
    .fall      (sel_fall_s)
  );

  // copi synchroniser; equal depth keeps data aligned with the p_clk edge pulses.
  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) begin
      copi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi};
    end
  end

  assign copi_s        = copi_sync_r[SYNC_STAGES-1];
  assign lead_s        = lead_edge(CPOL, pclk_rise_s, pclk_fall_s);
  assign trail_s       = lead_edge(CPOL, pclk_fall_s, pclk_rise_s);
  assign sample_s      = (CPHA == 0) ? lead_s : trail_s;
  assign shift_s       = (CPHA == 0) ? trail_s : lead_s;
  assign frame_start_s = (state_r == IDLE) && sel_fall_s;
  assign frame_word_s  = tx_ready ? {SPI_DATA_WIDTH{1'b0}} : txbuf_r;

  // TX buffer: a load wins over a same-cycle frame start, which took the old contents.
  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) begin
      txbuf_r  <= {SPI_DATA_WIDTH{1'b0}};
      tx_ready <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      txbuf_r  <= tx_data;
      tx_ready <= 1'b0;
    end else if (frame_start_s) begin
      tx_ready <= 1'b1;
    end
  end

  // Frame FSM with registered serial and status outputs.
  always_ff @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) begin
      state_r  <= IDLE;
      shreg_r  <= {SPI_DATA_WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      close_r  <= 1'b0;
      cipo     <= 1'b0;
      cipo_oe  <= 1'b0;
      rx_data  <= {SPI_DATA_WIDTH{1'b0}};
      rx_valid <= 1'b0;
      busy     <= 1'b0;
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
      tx_underrun <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
      tx_underrun <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (sel_fall_s) begin
            state_r <= SHIFT;
            shreg_r <= frame_word_s;
            cnt_r   <= {CNT_W{1'b0}};
            close_r <= 1'b0;
            cipo_oe <= 1'b1;
            busy    <= 1'b1;
            if (CPHA == 0) begin
              cipo <= frame_word_s[0];
            end
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
            tx_underrun <= tx_ready;
`endif
          end
        end
        SHIFT: begin
          if (cnt_r == CNT_FULL) begin
            rx_data  <= shreg_r;
            rx_valid <= 1'b1;
            busy     <= 1'b0;
            if (close_r || sel_rise_s) begin
              state_r <= IDLE;
              cipo_oe <= 1'b0;
              cipo    <= 1'b0;
            end else begin
              state_r <= DONE;
            end
          end else if (sample_s) begin
            shreg_r <= {copi_s, shreg_r[SPI_DATA_WIDTH-1:1]};
            cnt_r   <= cnt_r + CNT_W'(1);
            // Deselect racing the final sample still completes the frame.
            if (sel_rise_s && (cnt_r == CNT_LAST)) begin
              close_r <= 1'b1;
            end else if (sel_rise_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              cipo_oe <= 1'b0;
              cipo    <= 1'b0;
            end
          end else if (sel_rise_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            cipo_oe <= 1'b0;
            cipo    <= 1'b0;
          end else if (shift_s) begin
            cipo <= shreg_r[0];
          end
        end
        DONE: begin
          if (sel_rise_s) begin
            state_r <= IDLE;
            cipo_oe <= 1'b0;
            cipo    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cipo_oe <= 1'b0;
          cipo    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alpharetz_spi_peripheral.sv
// Bench for alpharetz_spi_peripheral: mode-0 and mode-3 instances driven by a
// pin-level controller, checked every cycle against an event-scheduled model.
module tb_alpharetz_spi_peripheral;

  localparam int W        = 8;
  localparam int S        = 2;
  localparam int HALF     = 4;
  localparam int LAT      = S + 1;
  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_DESEL = 2;

  logic         sys_clk = 1'b0;
  logic         async_rst;
  logic         p_clk    [2];
  logic         p_sel_n  [2];
  logic         copi     [2];
  logic         cipo     [2];
  logic         cipo_oe  [2];
  logic [W-1:0] tx_data  [2];
  logic         tx_valid [2];
  logic         tx_ready [2];
  logic [W-1:0] rx_data  [2];
  logic         rx_valid [2];
  logic         busy     [2];
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
  logic         tx_underrun [2];
`endif

  always #5 sys_clk = ~sys_clk;

  alpharetz_spi_peripheral #(.SPI_DATA_WIDTH(W), .CPOL(0), .CPHA(0), .SYNC_STAGES(S)) u_dut0 (
    .sys_clk(sys_clk), .async_rst(async_rst), .p_clk(p_clk[0]), .p_sel_n(p_sel_n[0]),
    .copi(copi[0]), .cipo(cipo[0]), .cipo_oe(cipo_oe[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .rx_data(rx_data[0]),
    .rx_valid(rx_valid[0]), .busy(busy[0])
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
    , .tx_underrun(tx_underrun[0])
`endif
  );

  alpharetz_spi_peripheral #(.SPI_DATA_WIDTH(W), .CPOL(1), .CPHA(1), .SYNC_STAGES(S)) u_dut1 (
    .sys_clk(sys_clk), .async_rst(async_rst), .p_clk(p_clk[1]), .p_sel_n(p_sel_n[1]),
    .copi(copi[1]), .cipo(cipo[1]), .cipo_oe(cipo_oe[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .rx_data(rx_data[1]),
    .rx_valid(rx_valid[1]), .busy(busy[1])
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
    , .tx_underrun(tx_underrun[1])
`endif
  );

  typedef struct {
    int           d;
    int           at;
    int           kind;
    logic [W-1:0] w;
    bit           close;
  } ev_t;

  ev_t          ev_q   [$];
  ev_t          keep_q [$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           rxv_seen [2] = '{0, 0};
  bit           load_m  [2];
  bit           m_full  [2];
  logic [W-1:0] m_buf   [2];
  logic [W-1:0] m_rxd   [2];
  logic [W-1:0] m_frame [2];
  logic         m_ready [2];
  logic         m_busy  [2];
  logic         m_oe    [2];
  logic         m_rxv   [2];
  logic         m_unr   [2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_ev(input int d, input int at, input int kind, input logic [W-1:0] w, input bit close);
    ev_t e;
    e.d = d; e.at = at; e.kind = kind; e.w = w; e.close = close;
    ev_q.push_back(e);
  endtask

  // Model: frame-level events land a fixed number of cycles after pin activity.
  always @(posedge sys_clk or posedge async_rst) begin
    if (async_rst) begin
      for (int d = 0; d < 2; d++) begin
        m_full[d] = 1'b0; m_buf[d] = '0; m_ready[d] = 1'b1; m_busy[d] = 1'b0;
        m_oe[d] = 1'b0; m_rxv[d] = 1'b0; m_unr[d] = 1'b0; m_rxd[d] = '0;
      end
      ev_q.delete();
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        load_m[d] = tx_valid[d] && m_ready[d];
        m_rxv[d]  = 1'b0;
        m_unr[d]  = 1'b0;
      end
      keep_q.delete();
      foreach (ev_q[i]) begin
        if (ev_q[i].at == cyc) begin
          case (ev_q[i].kind)
            EV_START: begin
              m_frame[ev_q[i].d] = m_full[ev_q[i].d] ? m_buf[ev_q[i].d] : '0;
              m_unr[ev_q[i].d]   = !m_full[ev_q[i].d];
              m_full[ev_q[i].d]  = 1'b0;
              m_ready[ev_q[i].d] = 1'b1;
              m_busy[ev_q[i].d]  = 1'b1;
              m_oe[ev_q[i].d]    = 1'b1;
            end
            EV_DONE: begin
              m_rxv[ev_q[i].d]  = 1'b1;
              m_rxd[ev_q[i].d]  = ev_q[i].w;
              m_busy[ev_q[i].d] = 1'b0;
              if (ev_q[i].close) m_oe[ev_q[i].d] = 1'b0;
            end
            default: begin
              m_busy[ev_q[i].d] = 1'b0;
              m_oe[ev_q[i].d]   = 1'b0;
            end
          endcase
        end else begin
          keep_q.push_back(ev_q[i]);
        end
      end
      ev_q = keep_q;
      for (int d = 0; d < 2; d++) begin
        if (load_m[d]) begin
          m_full[d] = 1'b1; m_buf[d] = tx_data[d]; m_ready[d] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every status output against the model.
  always @(negedge sys_clk) begin
    if (!async_rst) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy", d, busy[d], m_busy[d]);
        chk("cipo_oe", d, cipo_oe[d], m_oe[d]);
        chk("rx_valid", d, rx_valid[d], m_rxv[d]);
        chk("rx_data", d, rx_data[d], m_rxd[d]);
        chk("tx_ready", d, tx_ready[d], m_ready[d]);
        if (!m_oe[d]) chk("cipo_idle", d, cipo[d], 1'b0);
`ifdef ALPHARETZ_SPI_PERI_UNDERRUN_EN
        chk("tx_underrun", d, tx_underrun[d], m_unr[d]);
`endif
        if (rx_valid[d] === 1'b1) rxv_seen[d]++;
      end
    end
  end

  task automatic tx_write(input int d, input logic [W-1:0] w);
    int guard;
    guard = 0;
    while (!m_ready[d] && guard < 200) begin
      wait_cyc(1);
      guard++;
    end
    tx_data[d]  = w;
    tx_valid[d] = 1'b1;
    wait_cyc(1);
    tx_valid[d] = 1'b0;
  endtask

  task automatic reset_mid_frame();
    async_rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_cipo", d, cipo[d], 1'b0);
      chk("rst_cipo_oe", d, cipo_oe[d], 1'b0);
      chk("rst_tx_ready", d, tx_ready[d], 1'b1);
      chk("rst_rx_data", d, rx_data[d], 8'h00);
      chk("rst_rx_valid", d, rx_valid[d], 1'b0);
      chk("rst_busy", d, busy[d], 1'b0);
      p_sel_n[d] = 1'b1;
      p_clk[d]   = (d == 1);
      copi[d]    = 1'b0;
    end
    wait_cyc(3);
    async_rst = 1'b0;
    wait_cyc(4);
  endtask

  // Controller: abort_k < W deselects after that many samples; rst_at >= 0 resets before that bit.
  task automatic spi_frame(input int d, input logic [W-1:0] mosi, input int abort_k,
                           input bit close_same, input int rst_at, output logic [W-1:0] got_o);
    logic         cpol, cpha;
    logic [W-1:0] got, mask;
    int           nsamp;
    cpol = (d == 1); cpha = (d == 1);
    got = '0; nsamp = 0; got_o = '0;
    if (!cpha) copi[d] = mosi[0];
    p_sel_n[d] = 1'b0;
    push_ev(d, cyc + LAT, EV_START, '0, 1'b0);
    wait_cyc(2 * HALF);
    for (int i = 0; i < W; i++) begin
      if (i == rst_at) begin
        reset_mid_frame();
        return;
      end
      p_clk[d] = ~cpol;
      if (!cpha) begin
        got[i] = cipo[d]; nsamp++;
        if (i == W - 1) begin
          push_ev(d, cyc + LAT + 1, EV_DONE, mosi, close_same);
          if (close_same) p_sel_n[d] = 1'b1;
        end
      end else begin
        copi[d] = mosi[i];
      end
      wait_cyc(HALF);
      p_clk[d] = cpol;
      if (!cpha) begin
        if (i < W - 1) copi[d] = mosi[i+1];
      end else begin
        got[i] = cipo[d]; nsamp++;
        if (i == W - 1) begin
          push_ev(d, cyc + LAT + 1, EV_DONE, mosi, close_same);
          if (close_same) p_sel_n[d] = 1'b1;
        end
      end
      wait_cyc(HALF);
      if (nsamp == abort_k) break;
    end
    if (nsamp < W || !close_same) begin
      p_sel_n[d] = 1'b1;
      push_ev(d, cyc + LAT, EV_DESEL, '0, 1'b0);
    end
    wait_cyc(2 * HALF);
    mask = (nsamp >= W) ? {W{1'b1}} : W'((1 << nsamp) - 1);
    chk("cipo_bits", d, got & mask, m_frame[d] & mask);
    got_o = got;
  endtask

  initial begin
    logic [W-1:0] g, w_r;
    int           base, d_r, k_r;
    bit           c_r;
    async_rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      p_clk[d] = (d == 1); p_sel_n[d] = 1'b1; copi[d] = 1'b0;
      tx_data[d] = '0; tx_valid[d] = 1'b0;
    end
    wait_cyc(3);
    async_rst = 1'b0;
    wait_cyc(2);
    for (int d = 0; d < 2; d++) begin
      chk("reset_tx_ready", d, tx_ready[d], 1'b1);
      chk("reset_busy", d, busy[d], 1'b0);
      chk("reset_rx_data", d, rx_data[d], 8'h00);
      chk("reset_cipo_oe", d, cipo_oe[d], 1'b0);
    end

    tx_write(0, 8'hA5);
    spi_frame(0, 8'h3C, W, 1'b0, -1, g);
    chk("mode0_cipo_word", 0, g, 8'hA5);
    chk("mode0_rx_word", 0, rx_data[0], 8'h3C);
    chk("mode0_rx_pulses", 0, rxv_seen[0], 1);
    chk("mode0_tx_ready", 0, tx_ready[0], 1'b1);

    spi_frame(0, 8'h5A, 5, 1'b0, -1, g);
    chk("abort_rx_kept", 0, rx_data[0], 8'h3C);
    chk("abort_no_pulse", 0, rxv_seen[0], 1);
    chk("abort_busy", 0, busy[0], 1'b0);
    chk("abort_oe", 0, cipo_oe[0], 1'b0);

    tx_write(1, 8'h81);
    spi_frame(1, 8'hFF, W, 1'b0, -1, g);
    chk("mode3_cipo_word", 1, g, 8'h81);
    chk("mode3_rx_word", 1, rx_data[1], 8'hFF);

    spi_frame(0, 8'h55, W, 1'b0, -1, g);
    chk("empty_cipo_word", 0, g, 8'h00);
    chk("empty_rx_word", 0, rx_data[0], 8'h55);

    tx_write(0, 8'h3E);
    spi_frame(0, 8'hC3, W, 1'b0, 3, g);
    spi_frame(0, 8'h96, W, 1'b0, -1, g);
    chk("post_reset_rx", 0, rx_data[0], 8'h96);
    chk("post_reset_cipo", 0, g, 8'h00);

    base = rxv_seen[0];
    fork
      spi_frame(0, 8'h11, W, 1'b0, -1, g);
      begin
        wait_cyc(20);
        tx_write(0, 8'hE7);
      end
    join
    spi_frame(0, 8'h22, W, 1'b0, -1, g);
    chk("b2b_cipo_word", 0, g, 8'hE7);
    chk("b2b_pulses", 0, rxv_seen[0] - base, 2);
    chk("b2b_rx_word", 0, rx_data[0], 8'h22);

    spi_frame(0, 8'h6B, W, 1'b1, -1, g);
    chk("close_mode0_rx", 0, rx_data[0], 8'h6B);
    spi_frame(1, 8'h2D, W, 1'b1, -1, g);
    chk("close_mode3_rx", 1, rx_data[1], 8'h2D);

    for (int n = 0; n < 40; n++) begin
      d_r = int'($urandom_range(0, 1));
      w_r = W'($urandom);
      if ($urandom_range(0, 1) == 1) tx_write(d_r, W'($urandom));
      k_r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W - 1)) : W;
      c_r = (k_r == W) && ($urandom_range(0, 7) == 0);
      spi_frame(d_r, w_r, k_r, c_r, -1, g);
      if (k_r == W) chk("rand_rx_word", d_r, rx_data[d_r], w_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
